// File: rtl/alu_pkg.sv
// Shared types for the Exe-stage ALU front end and the ALU itself.
// Selection codes, MIPS opcode/funct values and the issue FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    SEL_SLL   = 4'h0,
    SEL_SRL   = 4'h1,
    SEL_MULT  = 4'h2,
    SEL_MULTU = 4'h3,
    SEL_DIV   = 4'h4,
    SEL_DIVU  = 4'h5,
    SEL_ADD   = 4'h6,
    SEL_ADDU  = 4'h7,
    SEL_SUB   = 4'h8,
    SEL_SUBU  = 4'h9,
    SEL_AND   = 4'hA,
    SEL_OR    = 4'hB,
    SEL_XOR   = 4'hC,
    SEL_NOR   = 4'hD,
    SEL_SLT   = 4'hE,
    SEL_SLTU  = 4'hF
  } alu_sel_e;

  typedef enum logic [1:0] {
    OPS_RS_RT,
    OPS_RT_SHAMT,
    OPS_SHAMT_RT,
    OPS_RS_IMM
  } opsel_e;

  typedef enum logic {
    EXT_SIGN,
    EXT_ZERO
  } ext_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPT,
    ST_RESP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS opcode/funct decoder for the ALU issue stage.
// Produces ALU select, operand routing, extension mode and status flags.
module alu_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rt_val,
  output alu_sel_e         sel,
  output opsel_e           opsel,
  output ext_e             ext,
  output logic             is_branch,
  output logic             is_bne,
  output logic             illegal,
  output logic             div_zero
);

  logic w_is_div;

  always_comb begin
    sel       = SEL_ADD;
    opsel     = OPS_RS_RT;
    ext       = EXT_SIGN;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = 1'b0;
    w_is_div  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL: begin
            sel   = SEL_SLL;
            opsel = OPS_RT_SHAMT;
          end
          F_SRL: begin
            sel   = SEL_SRL;
            opsel = OPS_SHAMT_RT;
          end
          F_MULT:  sel = SEL_MULT;
          F_MULTU: sel = SEL_MULTU;
          F_DIV: begin
            sel      = SEL_DIV;
            w_is_div = 1'b1;
          end
          F_DIVU: begin
            sel      = SEL_DIVU;
            w_is_div = 1'b1;
          end
          F_ADD:   sel = SEL_ADD;
          F_ADDU:  sel = SEL_ADDU;
          F_SUB:   sel = SEL_SUB;
          F_SUBU:  sel = SEL_SUBU;
          F_AND:   sel = SEL_AND;
          F_OR:    sel = SEL_OR;
          F_XOR:   sel = SEL_XOR;
          F_NOR:   sel = SEL_NOR;
          F_SLT:   sel = SEL_SLT;
          F_SLTU:  sel = SEL_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        sel   = SEL_ADD;
        opsel = OPS_RS_IMM;
      end
      OP_ADDIU: begin
        sel   = SEL_ADDU;
        opsel = OPS_RS_IMM;
      end
      OP_SLTI: begin
        sel   = SEL_SLT;
        opsel = OPS_RS_IMM;
      end
      OP_SLTIU: begin
        sel   = SEL_SLTU;
        opsel = OPS_RS_IMM;
      end
      OP_ANDI: begin
        sel   = SEL_AND;
        opsel = OPS_RS_IMM;
        ext   = EXT_ZERO;
      end
      OP_ORI: begin
        sel   = SEL_OR;
        opsel = OPS_RS_IMM;
        ext   = EXT_ZERO;
      end
      OP_XORI: begin
        sel   = SEL_XOR;
        opsel = OPS_RS_IMM;
        ext   = EXT_ZERO;
      end
      OP_BEQ: begin
        sel       = SEL_SUB;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        sel       = SEL_SUB;
        is_branch = 1'b1;
        is_bne    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign div_zero = w_is_div && (rt_val == '0);

endmodule

// File: rtl/alu_issue.sv
// ALU issue front end: decode, drive registered ALU, capture, respond.
// Optional macro ALU_ISSUE_DIV_ZERO_TRAP_EN traps div/divu with rt==0.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [15:0]      imm,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_branch_taken,
  output logic             out_illegal,
  output logic             out_div_zero
);

`ifdef ALU_ISSUE_DIV_ZERO_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e r_state;
  state_e w_next;

  alu_sel_e w_sel;
  opsel_e   w_opsel;
  ext_e     w_ext;
  logic     w_is_branch;
  logic     w_is_bne;
  logic     w_illegal;
  logic     w_div_zero;

  alu_decode #(.WIDTH(WIDTH)) u_dec (
    .opcode    (opcode),
    .funct     (funct),
    .rt_val    (rt_val),
    .sel       (w_sel),
    .opsel     (w_opsel),
    .ext       (w_ext),
    .is_branch (w_is_branch),
    .is_bne    (w_is_bne),
    .illegal   (w_illegal),
    .div_zero  (w_div_zero)
  );

  logic             w_accept;
  logic             w_skip;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_shamt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  // Instructions that never reach the ALU go straight to RESP.
  assign w_skip   = w_illegal || (TRAP_EN && w_div_zero);
  assign w_shamt  = {{(WIDTH-5){1'b0}}, shamt};
  assign w_imm    = (w_ext == EXT_ZERO) ?
                    {{(WIDTH-16){1'b0}}, imm} :
                    {{(WIDTH-16){imm[15]}}, imm};

  always_comb begin
    w_a = rs_val;
    w_b = rt_val;
    case (w_opsel)
      OPS_RT_SHAMT: begin
        w_a = rt_val;
        w_b = w_shamt;
      end
      OPS_SHAMT_RT: begin
        w_a = w_shamt;
        w_b = rt_val;
      end
      OPS_RS_IMM: w_b = w_imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_skip ? ST_RESP : ST_DRIVE;
      ST_DRIVE: w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_RESP;
      ST_RESP:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_RESP);
  end

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_sel_e         r_sel;
  logic             r_is_branch;
  logic             r_is_bne;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_branch;
  logic             r_illegal;
  logic             w_res_zero;

  assign w_res_zero = (alu_result == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= SEL_SLL;
      r_is_branch <= 1'b0;
      r_is_bne    <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      if (!w_skip) begin
        r_a         <= w_a;
        r_b         <= w_b;
        r_sel       <= w_sel;
        r_is_branch <= w_is_branch;
        r_is_bne    <= w_is_bne;
      end
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= w_illegal;
    end else if (r_state == ST_CAPT) begin
      r_result <= alu_result;
      r_zero   <= w_res_zero;
      r_branch <= r_is_branch && (r_is_bne ^ w_res_zero);
    end
  end

`ifdef ALU_ISSUE_DIV_ZERO_TRAP_EN
  logic r_div_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_div_zero <= 1'b0;
    else if (w_accept) r_div_zero <= w_div_zero;
  end

  assign out_div_zero = r_div_zero;
`else
  assign out_div_zero = 1'b0;
`endif

  assign alu_a            = r_a;
  assign alu_b            = r_b;
  assign alu_sel          = r_sel;
  assign out_result       = r_result;
  assign out_zero         = r_zero;
  assign out_branch_taken = r_branch;
  assign out_illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a one-cycle registered ALU model.
// Expected values are hand-computed per instruction vector.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [15:0] imm = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_branch_taken;
  logic        out_illegal;
  logic        out_div_zero;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .opcode           (opcode),
    .funct            (funct),
    .shamt            (shamt),
    .imm              (imm),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_sel          (alu_sel),
    .alu_result       (alu_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_zero         (out_zero),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal),
    .out_div_zero     (out_div_zero)
  );

  function automatic logic [31:0] alu_f(
    input logic [3:0]  s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (s)
      4'h0: return a << b[4:0];
      4'h1: return b >> a[4:0];
      4'h2, 4'h3: return a * b;
      4'h4: return (b == 0) ? '1 :
                   32'($signed(a) / $signed(b));
      4'h5: return (b == 0) ? '1 : a / b;
      4'h6, 4'h7: return a + b;
      4'h8, 4'h9: return a - b;
      4'hA: return a & b;
      4'hB: return a | b;
      4'hC: return a ^ b;
      4'hD: return ~(a | b);
      4'hE: return {31'b0, $signed(a) < $signed(b)};
      default: return {31'b0, a < b};
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(
    input logic [5:0]  op,
    input logic [5:0]  fn,
    input logic [4:0]  sh,
    input logic [15:0] im,
    input logic [31:0] rs,
    input logic [31:0] rt
  );
    @(negedge clk);
    opcode   = op;
    funct    = fn;
    shamt    = sh;
    imm      = im;
    rs_val   = rs;
    rt_val   = rt;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, exp_lat);
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ack_vld", out_valid, 1'b0);
    chk("ack_rdy", in_ready, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_sel", alu_sel, 4'h0);
    chk("rst_res", out_result, 32'h0);
    chk("rst_ill", out_illegal, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // addi rs=5, imm=-1
    send(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd0);
    chk("addi_sel", alu_sel, 4'h6);
    chk("addi_a", alu_a, 32'd5);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_rdy", in_ready, 1'b0);
    wait_valid("addi_lat", 2);
    chk("addi_res", out_result, 32'd4);
    chk("addi_z", out_zero, 1'b0);
    chk("addi_br", out_branch_taken, 1'b0);
    chk("addi_ill", out_illegal, 1'b0);
    ack();

    // srl rt=0x80000000 shamt=4
    send(6'h00, 6'h02, 5'd4, 16'h0, 32'h0, 32'h80000000);
    chk("srl_sel", alu_sel, 4'h1);
    chk("srl_a", alu_a, 32'd4);
    chk("srl_b", alu_b, 32'h80000000);
    wait_valid("srl_lat", 2);
    chk("srl_res", out_result, 32'h08000000);
    ack();

    // sll rt=1 shamt=31
    send(6'h00, 6'h00, 5'd31, 16'h0, 32'h0, 32'd1);
    chk("sll_a", alu_a, 32'd1);
    chk("sll_b", alu_b, 32'd31);
    wait_valid("sll_lat", 2);
    chk("sll_res", out_result, 32'h80000000);
    ack();

    // andi zero-extends the immediate
    send(6'h0C, 6'h00, 5'd0, 16'h8F0F, 32'hF0F01234, 32'h0);
    chk("andi_sel", alu_sel, 4'hA);
    chk("andi_b", alu_b, 32'h00008F0F);
    wait_valid("andi_lat", 2);
    chk("andi_res", out_result, 32'h00000204);
    ack();

    // slt -1 < 1 signed
    send(6'h00, 6'h2A, 5'd0, 16'h0, 32'hFFFFFFFF, 32'd1);
    chk("slt_sel", alu_sel, 4'hE);
    wait_valid("slt_lat", 2);
    chk("slt_res", out_result, 32'd1);
    ack();

    // beq taken
    send(6'h04, 6'h00, 5'd0, 16'h0, 32'd7, 32'd7);
    chk("beq_sel", alu_sel, 4'h8);
    chk("beq_b", alu_b, 32'd7);
    wait_valid("beq_lat", 2);
    chk("beq_z", out_zero, 1'b1);
    chk("beq_br", out_branch_taken, 1'b1);
    ack();

    // bne not taken
    send(6'h05, 6'h00, 5'd0, 16'h0, 32'd7, 32'd7);
    wait_valid("bne_lat", 2);
    chk("bne_z", out_zero, 1'b1);
    chk("bne_br", out_branch_taken, 1'b0);
    ack();

    // bne taken
    send(6'h05, 6'h00, 5'd0, 16'h0, 32'd7, 32'd8);
    wait_valid("bne2_lat", 2);
    chk("bne2_res", out_result, 32'hFFFFFFFF);
    chk("bne2_z", out_zero, 1'b0);
    chk("bne2_br", out_branch_taken, 1'b1);
    ack();

    // illegal opcode: response right after the accept edge
    send(6'h3F, 6'h00, 5'd0, 16'h1234, 32'd9, 32'd9);
    wait_valid("ill_lat", 0);
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_res", out_result, 32'h0);
    chk("ill_br", out_branch_taken, 1'b0);
    chk("ill_sel", alu_sel, 4'h8);
    chk("ill_rdy", in_ready, 1'b0);
    ack();

    // illegal R-type funct
    send(6'h00, 6'h3F, 5'd0, 16'h0, 32'd1, 32'd2);
    wait_valid("illf_lat", 0);
    chk("illf_flag", out_illegal, 1'b1);
    ack();

    // sub with the consumer stalling five cycles
    send(6'h00, 6'h22, 5'd0, 16'h0, 32'd10, 32'd3);
    chk("sub_sel", alu_sel, 4'h8);
    wait_valid("sub_lat", 2);
    chk("sub_ill", out_illegal, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_vld", out_valid, 1'b1);
      chk("stall_rdy", in_ready, 1'b0);
      chk("stall_res", out_result, 32'd7);
      chk("stall_sel", alu_sel, 4'h8);
    end
    ack();

    // reset while in DRIVE drops the operation
    send(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    chk("pre_rst_rdy", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rdy", in_ready, 1'b1);
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_sel", alu_sel, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_vld", out_valid, 1'b0);
    chk("post_rst_rdy", in_ready, 1'b1);

    // divu by zero
    send(6'h00, 6'h1B, 5'd0, 16'h0, 32'd100, 32'd0);
`ifdef ALU_ISSUE_DIV_ZERO_TRAP_EN
    wait_valid("dz_lat", 0);
    chk("dz_flag", out_div_zero, 1'b1);
    chk("dz_res", out_result, 32'h0);
    chk("dz_sel", alu_sel, 4'h0);
`else
    chk("dz_sel", alu_sel, 4'h5);
    wait_valid("dz_lat", 2);
    chk("dz_flag", out_div_zero, 1'b0);
`endif
    chk("dz_ill", out_illegal, 1'b0);
    ack();

    // divu 100/7 issues normally
    send(6'h00, 6'h1B, 5'd0, 16'h0, 32'd100, 32'd7);
    chk("div_sel", alu_sel, 4'h5);
    wait_valid("div_lat", 2);
    chk("div_res", out_result, 32'd14);
    chk("div_dz", out_div_zero, 1'b0);
    ack();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
